tern_sar_adc_ctrl: RTL

- Digital successive-approximation controller for the on-chip ADC front end.
- Drives the sample/hold switch and capacitive DAC code, and reads the analog comparator.
- Converts the final offset-binary code to balanced-ternary trits.
- Hands the trits to the downstream ternary ALU over a valid/ready handshake.

---
 rtl/tern_sar_adc_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/tern_sar_adc_ctrl.sv
// SAR ADC controller: sample/hold, binary search on the cap DAC, then conversion
// of the offset-binary result into balanced-ternary trits for the ternary ALU.
module tern_sar_adc_ctrl #(
  parameter int NBITS      = 6,
  parameter int NTRITS     = 4,
  parameter int SAMPLE_CYC = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cmp_in,
  output logic                sample,
  output logic [NBITS-1:0]    dac_code,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NBITS-1:0]    code,
  output logic [2*NTRITS-1:0] trits
);

  localparam int W    = SETTLE_CYC + 2;
  localparam int CMAX = (SAMPLE_CYC > W) ? ((SAMPLE_CYC > NTRITS) ? SAMPLE_CYC : NTRITS)
                                         : ((W > NTRITS) ? W : NTRITS);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int KW   = (NTRITS > 1) ? $clog2(NTRITS) : 1;

  localparam logic [1:0] T_Z = 2'b00;
  localparam logic [1:0] T_P = 2'b01;
  localparam logic [1:0] T_N = 2'b10;

  typedef enum logic [2:0] {IDLE, SAMPLE, TRIAL, CONV, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [PW-1:0]            ptr_q, ptr_d;
  logic                     sample_q, sample_d;
  logic [NBITS-1:0]         dac_q, dac_d;
  logic [NBITS-1:0]         code_q, code_d;
  logic [NTRITS-1:0][1:0]   trits_q, trits_d;
  logic signed [NBITS:0]    v_q, v_d, v_next;
  logic                     out_valid_q, out_valid_d;
  logic                     cmp_s1_q, cmp_s2_q;
  int                       v_int, r_int, t_int;

  // cmp_in is asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_s1_q <= 1'b0;
      cmp_s2_q <= 1'b0;
    end else begin
      cmp_s1_q <= cmp_in;
      cmp_s2_q <= cmp_s1_q;
    end
  end

  // One balanced-ternary digit step: r = v mod 3 in 0..2, digit 2 maps to -1
  always_comb begin
    v_int = int'(v_q);
    r_int = v_int % 3;
    if (r_int < 0) r_int = r_int + 3;
    t_int = (r_int == 2) ? -1 : r_int;
    v_next = (NBITS+1)'((v_int - t_int) / 3);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    sample_d    = sample_q;
    dac_d       = dac_q;
    code_d      = code_q;
    trits_d     = trits_q;
    v_d         = v_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SAMPLE;
          cnt_d    = '0;
          ptr_d    = PW'(NBITS - 1);
          sample_d = 1'b1;
          dac_d    = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == CW'(SAMPLE_CYC - 1)) begin
          state_d       = TRIAL;
          cnt_d         = '0;
          sample_d      = 1'b0;
          dac_d[ptr_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRIAL: begin
        if (cnt_q == CW'(W - 1)) begin
          cnt_d = '0;
          if (!cmp_s2_q) dac_d[ptr_q] = 1'b0;
          if (ptr_q != '0) begin
            ptr_d        = ptr_q - PW'(1);
            dac_d[ptr_d] = 1'b1;
          end else begin
            code_d  = dac_d;
            // offset binary to two's complement: invert MSB, sign-extend
            v_d     = {~dac_d[NBITS-1], ~dac_d[NBITS-1], dac_d[NBITS-2:0]};
            state_d = CONV;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CONV: begin
        trits_d[KW'(cnt_q)] = (t_int == 1) ? T_P : ((t_int == -1) ? T_N : T_Z);
        v_d = v_next;
        if (cnt_q == CW'(NTRITS - 1)) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ptr_q       <= '0;
      sample_q    <= 1'b0;
      dac_q       <= '0;
      code_q      <= '0;
      trits_q     <= '0;
      v_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      sample_q    <= sample_d;
      dac_q       <= dac_d;
      code_q      <= code_d;
      trits_q     <= trits_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sample    = sample_q;
  assign dac_code  = dac_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign code      = code_q;
  assign trits     = trits_q;

  // Every representable v is fully consumed by NTRITS digits
  a_conv_zero: assert property (@(posedge clk) disable iff (rst)
    (state_q == CONV && cnt_q == CW'(NTRITS - 1)) |-> (v_next == '0));

endmodule
